// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ps2_pkg
// Brief  : Shared types and constants for the PS/2 keyboard receiver:
//          receive FSM states, frame bit levels, special scancodes,
//          status-word bit positions and the I/O address.
// Rev    : 1.0  initial release
// ============================================================================
package ps2_pkg;

   // Receive FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Frame framing levels
   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;

   // Special scancodes
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

   // Status/data word layout
   localparam int RD_VALID_BIT = 31;
   localparam int RD_OVF_BIT   = 30;
   localparam int RD_FERR_BIT  = 29;

   // Processor I/O address of the read-only scancode word
   localparam logic [31:0] PS2_IO_ADDR = 32'd4099;

   // Odd parity: data bits plus parity bit must contain an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ps2_rx_fifo
// Brief  : Small synchronous scancode FIFO, 8-bit wide. Pointers carry one
//          extra wrap bit so full and empty are distinguishable. A push while
//          full is accepted only when a pop happens in the same cycle; a pop
//          while empty is ignored.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic [7:0] i_data,
   output logic       o_full,
   output logic       o_empty,
   output logic [7:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_do_push;
   logic        w_do_pop;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot the push needs
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_head    = r_mem[r_rptr[AW-1:0]];

   // Storage array: written only, no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_data;
      end
   end

   // Read/write pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + (AW+1)'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + (AW+1)'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ps2_rx_mmio
// Brief  : Memory-mapped PS/2 keyboard receiver. Synchronises the raw PS/2
//          lines, glitch-filters the clock, deserialises 11-bit frames,
//          checks start/parity/stop and queues good scancodes in a FIFO that
//          the processor drains through a single read-only status/data word.
//          Optional build macro PS2_RX_BREAK_FILTER_EN drops break sequences
//          (F0 xx) so that only make codes reach the FIFO.
// Rev    : 1.0  initial release
// ============================================================================
module ps2_rx_mmio
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        rd_en,
   output logic [31:0] rd_data
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] c_FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   // Synchronisers
   logic          r_clk_s1;
   logic          r_clk_s2;
   logic          r_dat_s1;
   logic          r_dat_s2;

   // Clock filter
   logic          r_filt;
   logic [FW-1:0] r_fcnt;
   logic          r_fall;

   // Receive FSM
   ps2_state_e    r_state;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic          r_okpar;
   logic [TW-1:0] r_tocnt;

   // Status flags
   logic          r_overflow;
   logic          r_frame_err;

   // Datapath decode
   logic          w_timeout;
   logic          w_stop_fall;
   logic          w_byte_ok;
   logic          w_err_evt;
   logic          w_push;
   logic          w_drop;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_head;

   // Two-flop synchronisers; lines idle high
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Clock glitch filter: level follows only after FILTER_LEN differing samples
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_filt <= 1'b1;
         r_fcnt <= '0;
         r_fall <= 1'b0;
      end else if (r_clk_s2 != r_filt) begin
         if (r_fcnt == c_FILT_LAST) begin
            r_filt <= r_clk_s2;
            r_fcnt <= '0;
            r_fall <= ~r_clk_s2;
         end else begin
            r_fcnt <= r_fcnt + FW'(1);
            r_fall <= 1'b0;
         end
      end else begin
         r_fcnt <= '0;
         r_fall <= 1'b0;
      end
   end

   assign w_timeout   = (r_state != ST_IDLE) && !r_fall && (r_tocnt == c_TO_LAST);
   assign w_stop_fall = (r_state == ST_STOP) && r_fall;
   assign w_byte_ok   = w_stop_fall && (r_dat_s2 == PS2_STOP_BIT) && r_okpar;
   assign w_err_evt   = (w_stop_fall && !w_byte_ok) || w_timeout;

   // Frame receive FSM with idle-clock timeout
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_okpar  <= 1'b0;
         r_tocnt  <= '0;
      end else begin
         if (r_state == ST_IDLE || r_fall) begin
            r_tocnt <= '0;
         end else begin
            r_tocnt <= r_tocnt + TW'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (r_fall && (r_dat_s2 == PS2_START_BIT)) begin
                  r_state  <= ST_DATA;
                  r_bitcnt <= '0;
                  r_shift  <= '0;
               end
            end
            ST_DATA: begin
               if (r_fall) begin
                  r_shift  <= {r_dat_s2, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd7) begin
                     r_state <= ST_PARITY;
                  end
               end
            end
            ST_PARITY: begin
               if (r_fall) begin
                  r_okpar <= odd_parity_ok(r_shift, r_dat_s2);
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (r_fall) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // A stalled link abandons the partial byte
         if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
         end
      end
   end

`ifdef PS2_RX_BREAK_FILTER_EN
   logic r_brk_pend;
   logic w_is_brk;
   logic w_is_ext;

   assign w_is_brk = (r_shift == PS2_BREAK_CODE);
   assign w_is_ext = (r_shift == PS2_EXT_CODE);
   // F0 itself and the key code following it are swallowed; E0 passes through
   assign w_push   = w_byte_ok && !w_is_brk && !(r_brk_pend && !w_is_ext);

   // Break-pending tracker: armed by F0, consumed by the next non-E0 byte
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_brk_pend <= 1'b0;
      end else if (w_err_evt) begin
         r_brk_pend <= 1'b0;
      end else if (w_byte_ok) begin
         if (w_is_brk) begin
            r_brk_pend <= 1'b1;
         end else if (!w_is_ext) begin
            r_brk_pend <= 1'b0;
         end
      end
   end
`else
   assign w_push = w_byte_ok;
`endif

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clock),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_pop   (rd_en),
      .i_data  (r_shift),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // Full means non-empty, so a concurrent read always makes room
   assign w_drop = w_push && w_full && !rd_en;

   // Sticky status flags: a read clears them, a same-cycle new event wins
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (rd_en) begin
            r_overflow <= 1'b0;
         end
         if (w_err_evt) begin
            r_frame_err <= 1'b1;
         end else if (rd_en) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   // Status/data word assembled from registered state
   always_comb begin
      rd_data               = '0;
      rd_data[RD_VALID_BIT] = !w_empty;
      rd_data[RD_OVF_BIT]   = r_overflow;
      rd_data[RD_FERR_BIT]  = r_frame_err;
      rd_data[7:0]          = w_empty ? 8'h00 : w_head;
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ps2_rx_mmio
// Brief  : Self-checking bench for ps2_rx_mmio. Frames are driven bit by bit
//          on the PS/2 lines; a queue model of the FIFO and flags predicts
//          every status word read back through rd_en.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ps2_rx_mmio;

   localparam int DEPTH = 4;
   localparam int HP    = 20;   // PS/2 clock half period in system cycles

   logic        clock    = 1'b0;
   logic        reset    = 1'b0;
   logic        ps2_clk  = 1'b1;
   logic        ps2_data = 1'b1;
   logic        rd_en    = 1'b0;
   logic [31:0] rd_data;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0] exp_q[$];
   bit         exp_ovf = 1'b0;
   bit         exp_ferr = 1'b0;
   bit         exp_brk = 1'b0;

   ps2_rx_mmio #(
      .FIFO_DEPTH     (DEPTH),
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (50000)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data)
   );

   always #10 clock = ~clock;

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] exp_word();
      logic [31:0] w;
      w     = '0;
      w[31] = (exp_q.size() != 0);
      w[30] = exp_ovf;
      w[29] = exp_ferr;
      if (exp_q.size() != 0) w[7:0] = exp_q[0];
      return w;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
`ifdef PS2_RX_BREAK_FILTER_EN
      if (b == 8'hF0) begin
         exp_brk = 1'b1;
         return;
      end
      if (exp_brk && b != 8'hE0) begin
         exp_brk = 1'b0;
         return;
      end
`endif
      if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(b);
   endfunction

   function automatic void model_err();
      exp_ferr = 1'b1;
      exp_brk  = 1'b0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Compare the word, then pulse rd_en for one cycle and update the model
   task automatic read_check(input string tag);
      check(tag, rd_data, exp_word());
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
   endtask

   // One PS/2 bit: data changes while clock high, optional short glitch low
   task automatic send_bit(input bit b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         tick(12);
         ps2_clk = 1'b0;
         tick(3);
         ps2_clk = 1'b1;
         tick(HP - 15);
      end else begin
         tick(HP);
      end
      ps2_clk = 1'b0;
      tick(HP);
      ps2_clk = 1'b1;
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par);
      return {1'b1, (~^d) ^ bad_par, d, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input int ga, input int gb);
      logic [10:0] f;
      f = make_frame(d, bad_par);
      for (int i = 0; i < 11; i++) send_bit(f[i], (i == ga) || (i == gb));
      ps2_data = 1'b1;
      tick(HP);
      if (bad_par) model_err();
      else model_byte(d);
   endtask

   // Start bit plus the first four data bits only
   task automatic send_partial(input logic [7:0] d);
      logic [10:0] f;
      f = make_frame(d, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0);
      ps2_data = 1'b1;
   endtask

   initial begin
      // Reset state
      tick(3);
      check("reset_word", rd_data, 32'h0000_0000);
      reset = 1'b1;
      tick(5);

      // Single good frame
      send_frame(8'h1C, 1'b0, -1, -1);
      check("frame_1c_word", rd_data, 32'h8000_001C);
      read_check("frame_1c_read");
      check("frame_1c_after", rd_data, 32'h0000_0000);

      // Parity error
      send_frame(8'h1C, 1'b1, -1, -1);
      check("parity_err_word", rd_data, 32'h2000_0000);
      read_check("parity_err_read");
      check("parity_err_after", rd_data, 32'h0000_0000);

      // Overflow: five frames into a four-entry FIFO
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, -1, -1);
      check("ovf_word", rd_data, 32'hC000_0001);
      for (int k = 0; k < 4; k++) read_check("ovf_read");
      read_check("ovf_empty");

      // Glitches while idle and mid-frame
      for (int k = 0; k < 3; k++) begin
         ps2_clk = 1'b0;
         tick(3);
         ps2_clk = 1'b1;
         tick(20);
      end
      send_frame(8'h5A, 1'b0, 3, 7);
      check("glitch_word", rd_data, 32'h8000_005A);
      read_check("glitch_read");
      read_check("glitch_empty");

      // Timeout on a stalled frame, then recovery
      send_partial(8'h29);
      tick(50100);
      model_err();
      read_check("timeout_ferr");
      send_frame(8'h29, 1'b0, -1, -1);
      read_check("timeout_recover");
      read_check("timeout_empty");

      // Break-code sequence
      send_frame(8'h1C, 1'b0, -1, -1);
      send_frame(8'hF0, 1'b0, -1, -1);
      send_frame(8'h1C, 1'b0, -1, -1);
      send_frame(8'hE0, 1'b0, -1, -1);
      send_frame(8'h75, 1'b0, -1, -1);
      while (exp_q.size() != 0) read_check("brk_read");
      read_check("brk_empty");

      // Reset in mid-frame
      send_partial(8'h77);
      reset = 1'b0;
      tick(3);
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
      exp_brk  = 1'b0;
      check("midreset_word", rd_data, 32'h0000_0000);
      reset = 1'b1;
      tick(5);
      send_frame(8'h33, 1'b0, -1, -1);
      check("midreset_33", rd_data, 32'h8000_0033);
      read_check("midreset_read");
      read_check("midreset_empty");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
